// File: rtl/pencere_serilestirici.sv
// Sliding 3x3 window producer for the serial median unit: collects columns,
// then streams the 9 window pixels plus one result slot per window.
module pencere_serilestirici #(
  parameter int PIXEL_BIT = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [3*PIXEL_BIT-1:0] sutun_i,
  input  logic                   sutun_gecerli_i,
  input  logic                   satir_basi_i,
  output logic                   sutun_hazir_o,
  output logic [PIXEL_BIT-1:0]   sayi_o,
  output logic                   medyan_rstn_o,
  output logic                   beklenen_hazir_o,
  output logic                   mesgul_o
);

  typedef enum logic {BOS, SERI} durum_t;

  localparam logic [3:0] K_SON = 4'd9;

  durum_t                 r_durum, w_durum_d;
  logic [3:0]             r_k, w_k_d;
  logic [1:0]             r_dolu, w_dolu_d;
  logic [3*PIXEL_BIT-1:0] r_s0, r_s1, r_s2;

  logic w_kabul;
  logic w_pencere_tam;
  logic w_son_dilim;

  assign w_son_dilim   = (r_durum == SERI) && (r_k == K_SON);
  assign sutun_hazir_o = !rst_i && ((r_durum == BOS) || w_son_dilim);
  assign w_kabul       = sutun_gecerli_i && sutun_hazir_o;

  always_comb begin
    w_dolu_d = r_dolu;
    if (w_kabul) begin
      if (satir_basi_i)          w_dolu_d = 2'd1;
      else if (r_dolu == 2'd3)   w_dolu_d = 2'd3;
      else                       w_dolu_d = r_dolu + 2'd1;
    end
  end

  assign w_pencere_tam = w_kabul && (w_dolu_d == 2'd3);

  always_comb begin
    w_durum_d = r_durum;
    w_k_d     = r_k;
    case (r_durum)
      BOS: begin
        if (w_pencere_tam) begin
          w_durum_d = SERI;
          w_k_d     = 4'd0;
        end
      end
      SERI: begin
        if (r_k == K_SON) begin
          // Back-to-back windows keep the median unit out of reset; its own
          // counter wraps from 9 to 0 in step with k.
          w_durum_d = w_pencere_tam ? SERI : BOS;
          w_k_d     = 4'd0;
        end else begin
          w_k_d = r_k + 4'd1;
        end
      end
      default: begin
        w_durum_d = BOS;
        w_k_d     = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum <= BOS;
      r_k     <= '0;
      r_dolu  <= '0;
      r_s0    <= '0;
      r_s1    <= '0;
      r_s2    <= '0;
    end else begin
      r_durum <= w_durum_d;
      r_k     <= w_k_d;
      r_dolu  <= w_dolu_d;
      if (w_kabul) begin
        r_s0 <= satir_basi_i ? '0 : r_s1;
        r_s1 <= satir_basi_i ? '0 : r_s2;
        r_s2 <= sutun_i;
      end
    end
  end

  // Column-major read: k/3 selects the column, k%3 selects top/middle/bottom.
  logic [PIXEL_BIT-1:0] w_piksel;
  always_comb begin
    w_piksel = '0;
    case (r_k)
      4'd0:    w_piksel = r_s0[3*PIXEL_BIT-1:2*PIXEL_BIT];
      4'd1:    w_piksel = r_s0[2*PIXEL_BIT-1:PIXEL_BIT];
      4'd2:    w_piksel = r_s0[PIXEL_BIT-1:0];
      4'd3:    w_piksel = r_s1[3*PIXEL_BIT-1:2*PIXEL_BIT];
      4'd4:    w_piksel = r_s1[2*PIXEL_BIT-1:PIXEL_BIT];
      4'd5:    w_piksel = r_s1[PIXEL_BIT-1:0];
      4'd6:    w_piksel = r_s2[3*PIXEL_BIT-1:2*PIXEL_BIT];
      4'd7:    w_piksel = r_s2[2*PIXEL_BIT-1:PIXEL_BIT];
      4'd8:    w_piksel = r_s2[PIXEL_BIT-1:0];
      default: w_piksel = '0;
    endcase
  end

  always_comb begin
    sayi_o           = '0;
    medyan_rstn_o    = 1'b0;
    beklenen_hazir_o = 1'b0;
    mesgul_o         = 1'b0;
    if (!rst_i && (r_durum == SERI)) begin
      medyan_rstn_o    = 1'b1;
      mesgul_o         = 1'b1;
      beklenen_hazir_o = (r_k == K_SON);
      sayi_o           = w_piksel;
    end
  end

endmodule

// File: tb/tb_pencere_serilestirici.sv
// Bench for pencere_serilestirici: column table driven through the handshake,
// expected pixel stream kept in a scoreboard queue and checked every cycle.
module tb_pencere_serilestirici;

  localparam int P = 8;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic [3*P-1:0] sutun_i = '0;
  logic           sutun_gecerli_i = 1'b0;
  logic           satir_basi_i = 1'b0;
  logic           sutun_hazir_o;
  logic [P-1:0]   sayi_o;
  logic           medyan_rstn_o;
  logic           beklenen_hazir_o;
  logic           mesgul_o;

  pencere_serilestirici #(.PIXEL_BIT(P)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .sutun_i          (sutun_i),
    .sutun_gecerli_i  (sutun_gecerli_i),
    .satir_basi_i     (satir_basi_i),
    .sutun_hazir_o    (sutun_hazir_o),
    .sayi_o           (sayi_o),
    .medyan_rstn_o    (medyan_rstn_o),
    .beklenen_hazir_o (beklenen_hazir_o),
    .mesgul_o         (mesgul_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [P-1:0] pix;
    logic         slot;
  } exp_t;

  typedef struct {
    logic        sb;
    logic [P-1:0] t, m, b;
    logic        burst;
    int unsigned gap;
  } vec_t;

  exp_t q[$];
  int   n_test = 0;
  int   n_fail = 0;

  logic [3*P-1:0] m_s0, m_s1, m_s2;
  int             m_dolu;

  task automatic chk(input string name, input int act, input int req);
    n_test++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_s0 = '0; m_s1 = '0; m_s2 = '0; m_dolu = 0;
  endtask

  task automatic model_accept(input logic sb, input logic [3*P-1:0] col);
    exp_t e;
    logic [3*P-1:0] w [3];
    if (sb) begin
      m_s0 = '0; m_s1 = '0; m_s2 = col; m_dolu = 1;
    end else begin
      m_s0 = m_s1; m_s1 = m_s2; m_s2 = col;
      m_dolu = (m_dolu == 3) ? 3 : m_dolu + 1;
    end
    if (m_dolu == 3) begin
      w[0] = m_s0; w[1] = m_s1; w[2] = m_s2;
      for (int c = 0; c < 3; c++)
        for (int r = 2; r >= 0; r--) begin
          e.pix  = w[c][r*P +: P];
          e.slot = 1'b0;
          q.push_back(e);
        end
      e.pix = '0; e.slot = 1'b1;
      q.push_back(e);
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send_col(input logic sb, input logic [P-1:0] t, m, b,
                          input logic exp_burst, input string name);
    logic rdy;
    bit   done = 0;
    sutun_i         = {t, m, b};
    satir_basi_i    = sb;
    sutun_gecerli_i = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_i) rdy = sutun_hazir_o;
      @(posedge clk_i);
      if (rdy) done = 1;
    end
    #1;
    satir_basi_i = 1'b0;
    if (!done) begin
      chk({name, "_accept_timeout"}, 0, 1);
    end else begin
      model_accept(sb, {t, m, b});
      chk({name, "_burst_start"}, int'(mesgul_o), int'(exp_burst));
    end
  endtask

  // Every cycle: gated outputs in reset, else scoreboard item or idle state.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      chk("rst_gating", int'({sutun_hazir_o, medyan_rstn_o, beklenen_hazir_o, mesgul_o, sayi_o}), 0);
    end else if (q.size() > 0) begin
      e = q.pop_front();
      chk("sayi", int'(sayi_o), int'(e.pix));
      chk("beklenen_hazir", int'(beklenen_hazir_o), int'(e.slot));
      chk("hazir_in_burst", int'(sutun_hazir_o), int'(e.slot));
      chk("busy_rstn", int'({mesgul_o, medyan_rstn_o}), 3);
    end else begin
      chk("idle", int'({sutun_hazir_o, medyan_rstn_o, beklenen_hazir_o, mesgul_o, sayi_o}),
          int'({1'b1, 1'b0, 1'b0, 1'b0, {P{1'b0}}}));
    end
  end

  vec_t tbl [9];

  initial begin
    tbl[0] = '{sb: 1'b1, t: 8'd1,  m: 8'd2,  b: 8'd3,  burst: 1'b0, gap: 0};
    tbl[1] = '{sb: 1'b0, t: 8'd4,  m: 8'd5,  b: 8'd6,  burst: 1'b0, gap: 0};
    tbl[2] = '{sb: 1'b0, t: 8'd7,  m: 8'd8,  b: 8'd9,  burst: 1'b1, gap: 0};
    tbl[3] = '{sb: 1'b0, t: 8'd10, m: 8'd11, b: 8'd12, burst: 1'b1, gap: 0};
    tbl[4] = '{sb: 1'b1, t: 8'd20, m: 8'd21, b: 8'd22, burst: 1'b0, gap: 0};
    tbl[5] = '{sb: 1'b0, t: 8'd23, m: 8'd24, b: 8'd25, burst: 1'b0, gap: 0};
    tbl[6] = '{sb: 1'b0, t: 8'd26, m: 8'd27, b: 8'd28, burst: 1'b1, gap: 0};
    tbl[7] = '{sb: 1'b0, t: 8'd30, m: 8'd31, b: 8'd32, burst: 1'b1, gap: 14};
    tbl[8] = '{sb: 1'b0, t: 8'd33, m: 8'd34, b: 8'd35, burst: 1'b1, gap: 3};

    model_reset();
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #1;

    for (int i = 0; i < 9; i++) begin
      send_col(tbl[i].sb, tbl[i].t, tbl[i].m, tbl[i].b, tbl[i].burst, $sformatf("vec%0d", i));
      if (tbl[i].gap > 0) begin
        // Row-start with valid low must not disturb the window.
        sutun_gecerli_i = 1'b0;
        satir_basi_i    = 1'b1;
        repeat (tbl[i].gap) @(posedge clk_i);
        #1 satir_basi_i = 1'b0;
      end
    end

    // Mid-burst reset at k=4 discards the window and empties the fill count.
    sutun_gecerli_i = 1'b0;
    repeat (12) @(posedge clk_i);
    #1;
    send_col(1'b0, 8'd40, 8'd41, 8'd42, 1'b1, "pre_rst");
    sutun_gecerli_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    q.delete();
    model_reset();
    chk("post_rst_busy", int'(mesgul_o), 0);
    chk("post_rst_rstn", int'(medyan_rstn_o), 0);
    send_col(1'b0, 8'd50, 8'd51, 8'd52, 1'b0, "rst_c1");
    send_col(1'b0, 8'd53, 8'd54, 8'd55, 1'b0, "rst_c2");
    send_col(1'b0, 8'd56, 8'd57, 8'd58, 1'b1, "rst_c3");
    sutun_gecerli_i = 1'b0;

    for (int i = 0; i < 30 && q.size() > 0; i++) @(posedge clk_i);
    repeat (3) @(posedge clk_i);
    #1 chk("drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
